// File: rtl/my_nios_onchip_mem_pkg.sv
// Shared constants, lane helper and per-port command decode type for the
// dual-port on-chip memory.
package my_nios_onchip_mem_pkg;

    localparam int RL_SHORT = 1;
    localparam int RL_LONG  = 2;

    function automatic int lane_count(input int data_w);
        return data_w / 8;
    endfunction

    typedef struct packed {
        logic we;
        logic re;
        logic in_range;
    } port_ctl_t;

endpackage

// File: rtl/my_nios_onchip_ram_core.sv
// True-dual-port byte-enabled RAM array with registered reads (old data on a
// same-cycle write). No reset, no forwarding: the wrapper resolves collisions.
module my_nios_onchip_ram_core
    import my_nios_onchip_mem_pkg::*;
#(
    parameter int    DATA_W    = 32,
    parameter int    ADDR_W    = 10,
    parameter int    DEPTH     = 1024,
    parameter string INIT_FILE = "onchip_mem_init_ram_0.hex"
) (
    input  logic                          clk,
    input  logic                          clken_i,
    input  logic [ADDR_W-1:0]             a_addr_i,
    input  logic                          a_we_i,
    input  logic [lane_count(DATA_W)-1:0] a_be_i,
    input  logic [DATA_W-1:0]             a_wdata_i,
    input  logic                          a_re_i,
    output logic [DATA_W-1:0]             a_rdata_o,
    input  logic [ADDR_W-1:0]             b_addr_i,
    input  logic                          b_we_i,
    input  logic [lane_count(DATA_W)-1:0] b_be_i,
    input  logic [DATA_W-1:0]             b_wdata_i,
    input  logic                          b_re_i,
    output logic [DATA_W-1:0]             b_rdata_o
);

    localparam int NB = lane_count(DATA_W);

    (* ram_init_file = INIT_FILE *)
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] a_rdata_q;
    logic [DATA_W-1:0] b_rdata_q;

    // The image name reaches the vendor flow only through the array attribute.
    if (INIT_FILE == "") begin : g_no_image
    end

    // Callers guarantee the two ports never enable the same lane of one word.
    always_ff @(posedge clk) begin
        if (clken_i) begin
            for (int lane = 0; lane < NB; lane++) begin
                if (a_we_i && a_be_i[lane]) begin
                    mem_q[a_addr_i][lane*8 +: 8] <= a_wdata_i[lane*8 +: 8];
                end
                if (b_we_i && b_be_i[lane]) begin
                    mem_q[b_addr_i][lane*8 +: 8] <= b_wdata_i[lane*8 +: 8];
                end
            end
            if (a_re_i) begin
                a_rdata_q <= mem_q[a_addr_i];
            end
            if (b_re_i) begin
                b_rdata_q <= mem_q[b_addr_i];
            end
        end
    end

    assign a_rdata_o = a_rdata_q;
    assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/my_nios_onchip_memory_dp.sv
// Dual-port Avalon-MM on-chip RAM: range check, s1-priority write merge,
// optional cross-port forwarding (ONCHIP_MEM_DP_FWD_EN) and read pipeline.
module my_nios_onchip_memory_dp
    import my_nios_onchip_mem_pkg::*;
#(
    parameter int    DATA_W       = 32,
    parameter int    ADDR_W       = 10,
    parameter int    DEPTH        = 1024,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = "onchip_mem_init_ram_0.hex"
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          clken,
    input  logic [ADDR_W-1:0]             s1_address,
    input  logic                          s1_chipselect,
    input  logic                          s1_read,
    input  logic                          s1_write,
    input  logic [lane_count(DATA_W)-1:0] s1_byteenable,
    input  logic [DATA_W-1:0]             s1_writedata,
    output logic [DATA_W-1:0]             s1_readdata,
    output logic                          s1_readdatavalid,
    input  logic [ADDR_W-1:0]             s2_address,
    input  logic                          s2_chipselect,
    input  logic                          s2_read,
    input  logic                          s2_write,
    input  logic [lane_count(DATA_W)-1:0] s2_byteenable,
    input  logic [DATA_W-1:0]             s2_writedata,
    output logic [DATA_W-1:0]             s2_readdata,
    output logic                          s2_readdatavalid
);

    localparam int              NB          = lane_count(DATA_W);
    localparam logic [ADDR_W:0] DEPTH_LIMIT = (ADDR_W+1)'(DEPTH);

    if (READ_LATENCY != RL_SHORT && READ_LATENCY != RL_LONG) begin : g_bad_latency
        $error("READ_LATENCY must be 1 or 2");
    end
    if (DEPTH > 2**ADDR_W || DEPTH < 1 || (DATA_W % 8) != 0) begin : g_bad_geometry
        $error("DEPTH must fit ADDR_W and DATA_W must be a multiple of 8");
    end

    // Index 0 is s1, index 1 is s2.
    logic [1:0][ADDR_W-1:0] addr;
    logic [1:0][NB-1:0]     be;
    logic [1:0][DATA_W-1:0] wdata;
    logic [1:0]             cs, rd, wr;
    port_ctl_t [1:0]        ctl;
    logic [1:0][NB-1:0]     be_eff;
    logic [1:0][DATA_W-1:0] core_rdata;
    logic [1:0][DATA_W-1:0] rdata_o;
    logic [1:0]             rvalid_o;
    logic                   dual_same;

    assign addr  = {s2_address, s1_address};
    assign be    = {s2_byteenable, s1_byteenable};
    assign wdata = {s2_writedata, s1_writedata};
    assign cs    = {s2_chipselect, s1_chipselect};
    assign rd    = {s2_read, s1_read};
    assign wr    = {s2_write, s1_write};

    for (genvar gi = 0; gi < 2; gi++) begin : g_decode
        logic in_range;
        assign in_range = ({1'b0, addr[gi]} < DEPTH_LIMIT);
        assign ctl[gi]  = port_ctl_t'{we:       cs[gi] & wr[gi] & in_range,
                                      re:       cs[gi] & rd[gi] & ~wr[gi],
                                      in_range: in_range};
    end

    // s1 owns every lane both ports enable on a shared word.
    assign dual_same = ctl[0].we & ctl[1].we & (addr[0] == addr[1]);
    assign be_eff[0] = be[0];
    assign be_eff[1] = be[1] & ~(dual_same ? be[0] : '0);

    my_nios_onchip_ram_core #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_core (
        .clk       (clk),
        .clken_i   (clken),
        .a_addr_i  (addr[0]),
        .a_we_i    (ctl[0].we),
        .a_be_i    (be_eff[0]),
        .a_wdata_i (wdata[0]),
        .a_re_i    (ctl[0].re & ctl[0].in_range),
        .a_rdata_o (core_rdata[0]),
        .b_addr_i  (addr[1]),
        .b_we_i    (ctl[1].we),
        .b_be_i    (be_eff[1]),
        .b_wdata_i (wdata[1]),
        .b_re_i    (ctl[1].re & ctl[1].in_range),
        .b_rdata_o (core_rdata[1])
    );

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic              valid1_q;
        logic              oor1_q;
        logic [DATA_W-1:0] merged;
        logic [DATA_W-1:0] stage1_data;

`ifdef ONCHIP_MEM_DP_FWD_EN
        localparam int OG = 1 - gi;
        logic [NB-1:0]     fwd_lanes_d;
        logic [NB-1:0]     fwd_lanes_q;
        logic [DATA_W-1:0] fwd_data_q;
        logic [DATA_W-1:0] fwd_bits;

        // The other port's write lanes override the old word the array returns.
        assign fwd_lanes_d = (ctl[gi].re && ctl[OG].we && addr[gi] == addr[OG]) ?
                             be_eff[OG] : '0;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                fwd_lanes_q <= '0;
                fwd_data_q  <= '0;
            end else if (clken) begin
                fwd_lanes_q <= fwd_lanes_d;
                fwd_data_q  <= wdata[OG];
            end
        end

        for (genvar li = 0; li < NB; li++) begin : g_lane
            assign fwd_bits[li*8 +: 8] = {8{fwd_lanes_q[li]}};
        end

        assign merged = (core_rdata[gi] & ~fwd_bits) | (fwd_data_q & fwd_bits);
`else
        assign merged = core_rdata[gi];
`endif

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                valid1_q <= 1'b0;
                oor1_q   <= 1'b0;
            end else if (clken) begin
                valid1_q <= ctl[gi].re;
                oor1_q   <= ~ctl[gi].in_range;
            end
        end

        assign stage1_data = (valid1_q && !oor1_q) ? merged : '0;

        // readdatavalid is gated by clken so a held result is consumed only once.
        if (READ_LATENCY == RL_LONG) begin : g_lat2
            logic              valid2_q;
            logic [DATA_W-1:0] data2_q;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    valid2_q <= 1'b0;
                    data2_q  <= '0;
                end else if (clken) begin
                    valid2_q <= valid1_q;
                    data2_q  <= stage1_data;
                end
            end

            assign rdata_o[gi]  = data2_q;
            assign rvalid_o[gi] = valid2_q & clken;
        end else begin : g_lat1
            assign rdata_o[gi]  = stage1_data;
            assign rvalid_o[gi] = valid1_q & clken;
        end
    end

    assign s1_readdata      = rdata_o[0];
    assign s1_readdatavalid = rvalid_o[0];
    assign s2_readdata      = rdata_o[1];
    assign s2_readdatavalid = rvalid_o[1];

endmodule

// File: tb/tb_my_nios_onchip_memory_dp.sv
// Directed bench for my_nios_onchip_memory_dp (DEPTH=1000, READ_LATENCY=2);
// forwarding expectations follow ONCHIP_MEM_DP_FWD_EN.
module tb_my_nios_onchip_memory_dp;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clken;
    logic [9:0]  s1_address, s2_address;
    logic        s1_chipselect, s1_read, s1_write;
    logic        s2_chipselect, s2_read, s2_write;
    logic [3:0]  s1_byteenable, s2_byteenable;
    logic [31:0] s1_writedata, s2_writedata;
    logic [31:0] s1_readdata, s2_readdata;
    logic        s1_readdatavalid, s2_readdatavalid;

    int checks = 0;
    int errors = 0;
    int n_got;
    int stall_pulses;
    logic [31:0] got [8];

`ifdef ONCHIP_MEM_DP_FWD_EN
    localparam logic [31:0] EXP_FWD_S2 = 32'hDEADBEEF;
    localparam logic [31:0] EXP_FWD_S1 = 32'hDEADF00D;
`else
    localparam logic [31:0] EXP_FWD_S2 = 32'h01020304;
    localparam logic [31:0] EXP_FWD_S1 = 32'hDEADBEEF;
`endif

    always #5 clk = ~clk;

    my_nios_onchip_memory_dp #(
        .DATA_W       (32),
        .ADDR_W       (10),
        .DEPTH        (1000),
        .READ_LATENCY (2),
        .INIT_FILE    ("")
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .clken            (clken),
        .s1_address       (s1_address),
        .s1_chipselect    (s1_chipselect),
        .s1_read          (s1_read),
        .s1_write         (s1_write),
        .s1_byteenable    (s1_byteenable),
        .s1_writedata     (s1_writedata),
        .s1_readdata      (s1_readdata),
        .s1_readdatavalid (s1_readdatavalid),
        .s2_address       (s2_address),
        .s2_chipselect    (s2_chipselect),
        .s2_read          (s2_read),
        .s2_write         (s2_write),
        .s2_byteenable    (s2_byteenable),
        .s2_writedata     (s2_writedata),
        .s2_readdata      (s2_readdata),
        .s2_readdatavalid (s2_readdatavalid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        $display("check %-16s observed=%h expected=%h", tag, obs, exp);
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic idle();
        s1_chipselect = 0; s1_read = 0; s1_write = 0; s1_address = '0;
        s1_byteenable = '0; s1_writedata = '0;
        s2_chipselect = 0; s2_read = 0; s2_write = 0; s2_address = '0;
        s2_byteenable = '0; s2_writedata = '0;
    endtask

    task automatic drive(input int p, input logic rd, input logic wr, input logic [9:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
        if (p == 1) begin
            s1_chipselect = 1; s1_read = rd; s1_write = wr; s1_address = a;
            s1_byteenable = be; s1_writedata = wd;
        end else begin
            s2_chipselect = 1; s2_read = rd; s2_write = wr; s2_address = a;
            s2_byteenable = be; s2_writedata = wd;
        end
    endtask

    function automatic logic [31:0] rdv(input int p);
        return {31'd0, (p == 1) ? s1_readdatavalid : s2_readdatavalid};
    endfunction

    function automatic logic [31:0] rdd(input int p);
        return (p == 1) ? s1_readdata : s2_readdata;
    endfunction

    task automatic write_word(input int p, input logic [9:0] a, input logic [31:0] d,
                              input logic [3:0] be);
        drive(p, 1'b0, 1'b1, a, be, d);
        to_pos();
        idle();
    endtask

    // Issue one read and check nothing after one edge, result after two.
    task automatic read_check(input string tag, input int p, input logic [9:0] a,
                              input logic [31:0] exp);
        drive(p, 1'b1, 1'b0, a, 4'h0, 32'h0);
        to_pos();
        idle();
        to_neg();
        check({tag, "_early"}, rdv(p), 32'd0);
        to_pos();
        to_neg();
        check({tag, "_valid"}, rdv(p), 32'd1);
        check({tag, "_data"}, rdd(p), exp);
        to_pos();
    endtask

    task automatic sample_mon(input int p);
        if (rdv(p) == 32'd1) begin
            if (clken !== 1'b1) stall_pulses++;
            if (n_got < 8) got[n_got] = rdd(p);
            n_got++;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        clken   = 1'b1;
        idle();
        repeat (3) @(posedge clk);
        #1;
        check("rst_s1_data", s1_readdata, 32'h0);
        check("rst_s1_valid", rdv(1), 32'd0);
        check("rst_s2_data", s2_readdata, 32'h0);
        check("rst_s2_valid", rdv(2), 32'd0);
        reset_n = 1'b1;
        to_pos();

        // Contents survive a reset.
        write_word(1, 10'h000, 32'h12345678, 4'hF);
        reset_n = 1'b0;
        to_pos();
        to_pos();
        reset_n = 1'b1;
        to_pos();
        read_check("retain0", 1, 10'h000, 32'h12345678);

        // Byte lanes.
        write_word(1, 10'h010, 32'hAABBCCDD, 4'hF);
        write_word(1, 10'h010, 32'h11223344, 4'b0101);
        read_check("lanes", 2, 10'h010, 32'hAA22CC44);

        // Same-cycle dual write: s1 wins lane 1.
        write_word(2, 10'h020, 32'h55667788, 4'hF);
        drive(1, 1'b0, 1'b1, 10'h020, 4'b0011, 32'h11111111);
        drive(2, 1'b0, 1'b1, 10'h020, 4'b0110, 32'h22222222);
        to_pos();
        idle();
        read_check("dualwr", 1, 10'h020, 32'h55221111);

        // Cross-port read during write, both directions.
        write_word(1, 10'h030, 32'h01020304, 4'hF);
        drive(1, 1'b0, 1'b1, 10'h030, 4'hF, 32'hDEADBEEF);
        drive(2, 1'b1, 1'b0, 10'h030, 4'h0, 32'h0);
        to_pos();
        idle();
        to_neg();
        to_pos();
        to_neg();
        check("fwd_s2_valid", rdv(2), 32'd1);
        check("fwd_s2_data", s2_readdata, EXP_FWD_S2);
        check("fwd_s1_novalid", rdv(1), 32'd0);
        to_pos();
        drive(2, 1'b0, 1'b1, 10'h030, 4'b0011, 32'hCAFEF00D);
        drive(1, 1'b1, 1'b0, 10'h030, 4'h0, 32'h0);
        to_pos();
        idle();
        to_neg();
        to_pos();
        to_neg();
        check("fwd_s1_data", s1_readdata, EXP_FWD_S1);
        to_pos();
        read_check("fwd_commit", 2, 10'h030, 32'hDEADF00D);

        // Same-port read right after write.
        write_word(2, 10'h050, 32'h600DCAFE, 4'hF);
        read_check("rdafterwr", 2, 10'h050, 32'h600DCAFE);

        // read+write together: write only, no valid.
        drive(1, 1'b1, 1'b1, 10'h060, 4'hF, 32'h77777777);
        to_pos();
        idle();
        to_neg();
        check("rw_novalid1", rdv(1), 32'd0);
        to_pos();
        to_neg();
        check("rw_novalid2", rdv(1), 32'd0);
        to_pos();
        read_check("rw_commit", 1, 10'h060, 32'h77777777);

        // Burst with a 3-cycle clken stall.
        for (int i = 0; i < 4; i++) write_word(2, 10'h040 + 10'(i), 32'hB0000040 + 32'(i), 4'hF);
        n_got = 0;
        stall_pulses = 0;
        for (int c = 0; c < 12; c++) begin
            idle();
            clken = (c >= 2 && c <= 4) ? 1'b0 : 1'b1;
            if (c <= 1) drive(1, 1'b1, 1'b0, 10'h040 + 10'(c), 4'h0, 32'h0);
            else if (c <= 5) drive(1, 1'b1, 1'b0, 10'h042, 4'h0, 32'h0);
            else if (c == 6) drive(1, 1'b1, 1'b0, 10'h043, 4'h0, 32'h0);
            to_neg();
            sample_mon(1);
            to_pos();
        end
        clken = 1'b1;
        check("burst_count", 32'(n_got), 32'd4);
        check("burst_stall", 32'(stall_pulses), 32'd0);
        for (int i = 0; i < 4; i++) check($sformatf("burst_d%0d", i), got[i], 32'hB0000040 + 32'(i));

        // Reset mid-burst drops the remaining results.
        n_got = 0;
        stall_pulses = 0;
        for (int c = 0; c < 10; c++) begin
            idle();
            if (c <= 3) drive(2, 1'b1, 1'b0, 10'h040 + 10'(c), 4'h0, 32'h0);
            reset_n = (c == 4 || c == 5) ? 1'b0 : 1'b1;
            to_neg();
            sample_mon(2);
            if (c == 4) check("rstmid_data", s2_readdata, 32'h0);
            to_pos();
        end
        check("rstmid_count", 32'(n_got), 32'd2);
        check("rstmid_d0", got[0], 32'hB0000040);
        check("rstmid_d1", got[1], 32'hB0000041);

        // Out of range with DEPTH=1000.
        write_word(1, 10'd999, 32'h99999999, 4'hF);
        write_word(1, 10'd1000, 32'hFFFFFFFF, 4'hF);
        read_check("oor1000", 1, 10'd1000, 32'h0);
        read_check("word999", 2, 10'd999, 32'h99999999);
        read_check("oor1023", 2, 10'd1023, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
